// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller: access-size codes,
// controller state encoding and byte-lane helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Little-endian lanes: a == 0 selects bits [7:0].
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = 4'b0011 << a;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_RSVD) ||
               (size == SZ_HALF && a[0]) ||
               (size == SZ_WORD && a != 2'b00);
    endfunction

    // Store data is replicated across lanes so the lane mask alone picks the target.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side load/store port and memory-side block-RAM port of the controller.
// Handshake: the core raises req with stable we/size/sign_ext/addr/wdata and must keep
// them stable while stall=1; the access completes on the first rising edge with stall=0.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 8
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              stall;
    logic              misalign;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] bad_addr;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, stall, misalign, err_cnt, bad_addr
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, stall, misalign, err_cnt, bad_addr
    );
endinterface

interface mem_bus_if #(
    parameter int MEM_AW = 10
);
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword from a memory word and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  a,
    output logic [31:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_rdata[{a, 3'b000} +: 8];
        half_v = a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        data   = mem_rdata;
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{sign_ext & half_v[15]}}, half_v};
            default: data = mem_rdata;
        endcase
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between the core and a synchronous block RAM with
// configurable read latency, byte lanes, extension and misalignment logging.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 1,
    parameter int ERR_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave core,
    mem_bus_if.master      mem,
    output state_t         state_dbg
);
    localparam logic [2:0] LAT = 3'(LATENCY);

    state_t            state, state_next;
    logic [2:0]        cnt;
    logic [1:0]        lat_size;
    logic [1:0]        lat_a;
    logic              lat_sign;
    logic [31:0]       rdata_q;
    logic [31:0]       aligned;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [ADDR_W-1:0] bad_addr_q;
    logic              misalign_c;
    logic              stall_c;
    logic              mem_en_c;
    logic [3:0]        mem_we_c;
    logic              accept_load;
    logic              capture;
    logic              log_err;

    assign misalign_c = core.req & is_misaligned(core.size, core.addr[1:0]);

    // Requests are only taken in IDLE and never while reset is held, so the
    // handshake outputs are all zero during reset even if req is still high.
    always_comb begin
        state_next  = state;
        stall_c     = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 4'b0000;
        accept_load = 1'b0;
        capture     = 1'b0;
        log_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst && core.req) begin
                    if (misalign_c) begin
                        log_err = 1'b1;
                    end else if (core.we) begin
                        mem_en_c = 1'b1;
                        mem_we_c = lane_mask(core.size, core.addr[1:0]);
                    end else begin
                        mem_en_c    = 1'b1;
                        stall_c     = 1'b1;
                        accept_load = 1'b1;
                        state_next  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (cnt == LAT) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 3'd0;
            lat_size <= SZ_BYTE;
            lat_a    <= 2'b00;
            lat_sign <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            if (accept_load) begin
                cnt      <= 3'd1;
                lat_size <= core.size;
                lat_a    <= core.addr[1:0];
                lat_sign <= core.sign_ext;
            end else if (state == ST_WAIT && !capture) begin
                cnt <= cnt + 3'd1;
            end
            if (capture) begin
                rdata_q <= aligned;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q  <= '0;
            bad_addr_q <= '0;
        end else if (log_err) begin
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            bad_addr_q <= core.addr;
        end
    end

    mem_load_align u_align (
        .mem_rdata (mem.mem_rdata),
        .size      (lat_size),
        .sign_ext  (lat_sign),
        .a         (lat_a),
        .data      (aligned)
    );

    assign core.rdata    = rdata_q;
    assign core.stall    = stall_c;
    assign core.misalign = misalign_c;
    assign core.err_cnt  = err_cnt_q;
    assign core.bad_addr = bad_addr_q;

    // Upper address bits are dropped, so accesses wrap around the memory.
    assign mem.mem_en    = mem_en_c;
    assign mem.mem_we    = mem_we_c;
    assign mem.mem_addr  = core.addr[MEM_AW+1:2];
    assign mem.mem_wdata = store_data(core.size, core.wdata);

    assign state_dbg = state;
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data-memory controller between the MIPS core's load/store port and a synchronous block-RAM data memory.
- Adds byte/halfword/word access with sign or zero extension, and byte-lane write enables.
- Supports a configurable memory read latency, with a stall handshake back to the core.
- Detects misaligned accesses and logs them in a saturating error counter plus a last-bad-address register.
- Replaces the direct core-to-data_mem connection in the top level.

Parameters:
ADDR_W, 32, width of the core byte address
MEM_AW, 10, memory word-address width (depth = 2**MEM_AW words)
LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..7
ERR_W, 8, width of the misalignment error counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  1  core access request; held stable while stall=1
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-justified
rdata  out  32  load result, registered
stall  out  1  core must hold the current instruction
misalign  out  1  current request is illegal (combinational)
err_cnt  out  ERR_W  saturating count of misaligned requests
bad_addr  out  ADDR_W  address of the most recent misaligned request
mem_en  out  1  memory enable
mem_we  out  4  byte-lane write enables
mem_addr  out  MEM_AW  word address = addr[MEM_AW+1:2]
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, load counter=0, rdata=0, err_cnt=0, bad_addr=0.
  - Combinational outputs are then 0: stall, mem_en, mem_we.
- Byte lanes are little-endian: addr[1:0]=0 selects bits[7:0].
- misalign = req & (size==11 | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0)).
- Misaligned request:
  - No memory access; stall=0; rdata holds its value.
  - err_cnt increments (saturates at all-ones); bad_addr<=addr on that edge.
- FSM states are IDLE, WAIT and DONE.
- IDLE, legal store:
  - Same cycle: mem_en=1, mem_we=lane mask.
  - Lane masks: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - mem_wdata = {4{wdata[7:0]}} for bytes, {2{wdata[15:0]}} for halves, wdata for words.
  - stall=0; store completes in 1 cycle; stay IDLE.
- IDLE, legal load:
  - mem_en=1, mem_we=0, stall=1.
  - Latch size, sign_ext and addr[1:0]; counter<=1; go to WAIT.
- WAIT:
  - stall=1, mem_en=0.
  - While counter<LATENCY, increment counter.
  - When counter==LATENCY: rdata<=aligned/extended mem_rdata, then go to DONE.
- DONE:
  - stall=0, rdata valid, req ignored.
  - Next state is IDLE; the core advances on this edge.
- Load timing: stall high for exactly LATENCY+1 cycles after the request cycle inclusive; rdata is valid LATENCY+1 edges after acceptance.
- Load alignment/extension uses the latched values, not the live inputs:
  - byte: mem_rdata[8*a+7:8*a], a=addr[1:0];
  - half: the 16-bit lane at 16*a[1];
  - then sign- or zero-extend to 32 bits.
- Address bits above MEM_AW+1 are ignored (wrap-around).
- req=0 in IDLE: no memory activity, all outputs hold.
- Reset mid-load: the FSM aborts, stall drops immediately, and rdata is cleared.

Decomposition:
- Shared package (mem_pkg):
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - FSM state encoding;
  - lane-mask function.
- One sub-module, mem_load_align: combinational extraction plus sign/zero extension from {mem_rdata, size, sign_ext, a[1:0]}.

Test Plan:
- LATENCY=1, memory word 0 = 0x8899AABB; lb at addr 0x2 with sign_ext=1 -> stall 2 cycles, rdata=0xFFFFFF99.
  - Repeat with sign_ext=0 -> rdata=0x00000099.
- sb wdata=0x5A at addr 0x7 -> same cycle mem_we=1000, mem_addr=1, mem_wdata=0x5A5A5A5A, stall=0.
  - Then lw at addr 0x4 -> rdata[31:24]=0x5A.
- lh at addr 0x3 -> misalign=1, stall=0, mem_en=0, err_cnt=1, bad_addr=0x3, rdata unchanged.
  - After 300 misaligned requests with ERR_W=8 -> err_cnt=0xFF.
- LATENCY=4; lw at addr 0x10 with mem_rdata=0x12345678 presented 4 cycles after mem_en -> stall high 5 cycles, rdata=0x12345678.
  - The following DONE cycle ignores req.
- rst asserted low during WAIT (LATENCY=4, 2nd cycle) -> stall=0 immediately, rdata=0.
  - After release, a fresh lw completes normally.
- size=11 at aligned address 0x0 -> misalign=1, no memory access, err_cnt increments.
